// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU with registered result and an iterative RV-M multiply/divide unit.
// Define ALU_SEQ_MULDIV_EN to build the multiply/divide datapath; otherwise ops 9..15 return 0 in one cycle.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            arith,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            eq
);
  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SLT = 4'd1,  OP_SLTU = 4'd2,  OP_XOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_AND = 4'd5,  OP_SLL  = 4'd6,  OP_SR  = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8,  OP_MUL = 4'd9,  OP_MULH = 4'd10, OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_REM = 4'd14, OP_REMU = 4'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   res_reg, alu_res, md_res;
  logic              eq_reg, accept, is_md, md_last;
  logic [SH_W-1:0]   shamt;
  logic signed [XLEN-1:0] sra_res;

  assign in_ready  = (state_reg == IDLE) || (state_reg == DONE && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_reg == DONE);
  assign res       = res_reg;
  assign eq        = eq_reg;

  assign shamt   = src_b[SH_W-1:0];
  // Kept as its own signed net so the select below cannot demote >>> to a logical shift.
  assign sra_res = $signed(src_a) >>> shamt;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SR:   alu_res = arith ? sra_res : (src_a >> shamt);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CNT_W = $clog2(XLEN) + 1;

  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  acc_reg, qr_reg, opnd_reg;
  logic [3:0]       md_op_reg;
  logic             sa_reg, sb_reg, bz_reg;
  logic             md_signed, a_neg, b_neg, is_div;
  logic [XLEN-1:0]  a_mag, b_mag, mulh_neg;
  logic [XLEN:0]    add_sum, div_shift, div_diff;

  assign is_md     = (op >= OP_MUL);
  assign md_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = md_signed && src_a[XLEN-1];
  assign b_neg     = md_signed && src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign is_div    = (md_op_reg[3:2] == 2'b11);
  assign md_last   = (cnt_reg == '0);

  // acc:qr is the running product (multiply) or remainder:quotient (divide).
  assign add_sum   = {1'b0, acc_reg} + {1'b0, (qr_reg[0] ? opnd_reg : {XLEN{1'b0}})};
  assign div_shift = {acc_reg, qr_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  // High half of the negated double-width product.
  assign mulh_neg  = ~acc_reg + {{(XLEN-1){1'b0}}, (qr_reg == '0)};

  always_comb begin
    md_res = '0;
    case (md_op_reg)
      OP_MUL:   md_res = qr_reg;
      OP_MULH:  md_res = (sa_reg ^ sb_reg) ? mulh_neg : acc_reg;
      OP_MULHU: md_res = acc_reg;
      OP_DIV:   md_res = bz_reg ? '1 : ((sa_reg ^ sb_reg) ? -qr_reg : qr_reg);
      OP_DIVU:  md_res = qr_reg;
      OP_REM:   md_res = sa_reg ? -acc_reg : acc_reg;
      OP_REMU:  md_res = acc_reg;
      default:  md_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      qr_reg    <= '0;
      opnd_reg  <= '0;
      md_op_reg <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      bz_reg    <= 1'b0;
    end else if (accept && is_md) begin
      cnt_reg   <= CNT_W'(XLEN);
      acc_reg   <= '0;
      qr_reg    <= a_mag;
      opnd_reg  <= b_mag;
      md_op_reg <= op;
      sa_reg    <= a_neg;
      sb_reg    <= b_neg;
      bz_reg    <= (src_b == '0);
    end else if (state_reg == BUSY && !md_last) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (is_div) begin
        // Restoring step: keep the difference only when it did not go negative.
        if (!div_diff[XLEN]) begin
          acc_reg <= div_diff[XLEN-1:0];
          qr_reg  <= {qr_reg[XLEN-2:0], 1'b1};
        end else begin
          acc_reg <= div_shift[XLEN-1:0];
          qr_reg  <= {qr_reg[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_reg <= add_sum[XLEN:1];
        qr_reg  <= {add_sum[0], qr_reg[XLEN-1:1]};
      end
    end
  end
`else
  assign is_md   = 1'b0;
  assign md_last = 1'b0;
  assign md_res  = '0;
`endif

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = is_md ? BUSY : DONE;
        BUSY:    if (md_last) state_next = DONE;
        DONE: begin
          if (accept)         state_next = is_md ? BUSY : DONE;
          else if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg <= '0;
      eq_reg  <= 1'b0;
    end else if (accept) begin
      eq_reg <= (src_a == src_b);
      if (!is_md) res_reg <= alu_res;
    end else if (!flush && state_reg == BUSY && md_last) begin
      res_reg <= md_res;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected results at accept, a monitor pops on each output handshake.
module tb_alu_seq;
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SLT = 4'd1,  OP_SLTU = 4'd2,  OP_XOR = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4,  OP_AND = 4'd5,  OP_SLL  = 4'd6,  OP_SR  = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8,  OP_MUL = 4'd9,  OP_MULH = 4'd10, OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_REM = 4'd14, OP_REMU = 4'd15;
`ifdef ALU_SEQ_MULDIV_EN
  localparam int MD_LAT = 33;
  localparam logic BUSY_READY = 1'b0;
`else
  localparam int MD_LAT = 0;
  localparam logic BUSY_READY = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, arith, flush, out_valid, out_ready, eq;
  logic [3:0]  op;
  logic [31:0] src_a, src_b, res;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        eq;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .arith(arith), .src_a(src_a), .src_b(src_b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .eq(eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Output handshakes are sampled on the falling edge; they retire on the next rising edge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: res=%h eq=%b with nothing outstanding", res, eq);
        end else begin
          e = sb.pop_front();
          if (res !== e.res || eq !== e.eq) begin
            errors++;
            $display("FAIL %s: res=%h eq=%b, required res=%h eq=%b", e.name, res, eq, e.res, e.eq);
          end else begin
            $display("  %s: res=%h eq=%b cycle=%0d", e.name, res, eq, cyc);
          end
          if (e.lat >= 0) begin
            checks++;
            if (cyc - e.acc != e.lat) begin
              errors++;
              $display("FAIL %s_latency: %0d edges, required %0d", e.name, cyc - e.acc, e.lat);
            end
          end
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input string nm, input logic [3:0] o, input logic ar, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e, input int lat, input bit push);
    bit ok = 1'b0;
    int acc = 0;
    in_valid = 1'b1; op = o; arith = ar; src_a = a; src_b = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        ok = 1'b1;
        acc = cyc + 1;
      end
      @(posedge clk);
      if (ok && push) sb.push_back('{nm, e, (a == b), acc, lat});
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready never seen, required within 200 cycles", nm);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !out_valid;
    end
    @(posedge clk); #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    int start, seen;
    rst_n = 1'b1; in_valid = 1'b0; op = '0; arith = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; out_ready = 1'b1;
    fork monitor(); join_none
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_res", res, 32'd0);
    chk("reset_eq", {31'b0, eq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("ADD_5_7",      OP_ADD,  1'b0, 32'd5,        32'd7,        32'd12,       0, 1);
    issue("ADD_wrap",     OP_ADD,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 1);
    issue("ADD_arith_ign",OP_ADD,  1'b1, 32'd3,        32'd4,        32'd7,        0, 1);
    issue("SUB_5_7",      OP_SUB,  1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, 0, 1);
    issue("SUB_eq",       OP_SUB,  1'b0, 32'd9,        32'd9,        32'd0,        0, 1);
    issue("SLT_neg1_1",   OP_SLT,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 1);
    issue("SLTU_neg1_1",  OP_SLTU, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 1);
    issue("SLT_1_neg1",   OP_SLT,  1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        0, 1);
    issue("SLTU_1_neg1",  OP_SLTU, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd1,        0, 1);
    issue("XOR",          OP_XOR,  1'b0, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 0, 1);
    issue("OR",           OP_OR,   1'b0, 32'h12340000, 32'h00005678, 32'h12345678, 0, 1);
    issue("AND",          OP_AND,  1'b0, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5, 0, 1);
    issue("SLL_lowbits",  OP_SLL,  1'b0, 32'd1,        32'h23,       32'd8,        0, 1);
    issue("SRA_8000",     OP_SR,   1'b1, 32'h80000000, 32'd4,        32'hF8000000, 0, 1);
    issue("SRL_8000",     OP_SR,   1'b0, 32'h80000000, 32'd4,        32'h08000000, 0, 1);
    issue("SRA_pos_low",  OP_SR,   1'b1, 32'h7FFFFFFF, 32'h24,       32'h07FFFFFF, 0, 1);
    wait_drain();

    start = cyc;
    for (int i = 0; i < 10; i++)
      issue($sformatf("ADD_b2b_%0d", i), OP_ADD, 1'b0, 32'(i), 32'd100, 32'(i + 100), 0, 1);
    chk("b2b_cycles", 32'(cyc - start), 32'd10);
    wait_drain();

`ifdef ALU_SEQ_MULDIV_EN
    issue("MULHU_ff_ff",  OP_MULHU,1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MD_LAT, 1);
    issue("MULH_ff_ff",   OP_MULH, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        MD_LAT, 1);
    issue("MUL_ff_ff",    OP_MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        MD_LAT, 1);
    issue("MUL_3_4",      OP_MUL,  1'b0, 32'd3,        32'd4,        32'd12,       MD_LAT, 1);
    issue("MUL_m2_3",     OP_MUL,  1'b0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, MD_LAT, 1);
    issue("MULH_m2_3",    OP_MULH, 1'b0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, MD_LAT, 1);
    issue("DIVU_7_0",     OP_DIVU, 1'b0, 32'd7,        32'd0,        32'hFFFFFFFF, MD_LAT, 1);
    issue("REMU_7_0",     OP_REMU, 1'b0, 32'd7,        32'd0,        32'd7,        MD_LAT, 1);
    issue("DIV_m7_0",     OP_DIV,  1'b0, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, MD_LAT, 1);
    issue("REM_m7_0",     OP_REM,  1'b0, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, MD_LAT, 1);
    issue("DIV_ovf",      OP_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MD_LAT, 1);
    issue("REM_ovf",      OP_REM,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        MD_LAT, 1);
    issue("DIV_m7_2",     OP_DIV,  1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, MD_LAT, 1);
    issue("REM_m7_2",     OP_REM,  1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, MD_LAT, 1);
    issue("DIV_7_m2",     OP_DIV,  1'b0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, MD_LAT, 1);
    issue("REM_7_m2",     OP_REM,  1'b0, 32'd7,        32'hFFFFFFFE, 32'd1,        MD_LAT, 1);
    issue("DIVU_100_7",   OP_DIVU, 1'b0, 32'd100,      32'd7,        32'd14,       MD_LAT, 1);
    issue("REMU_100_7",   OP_REMU, 1'b0, 32'd100,      32'd7,        32'd2,        MD_LAT, 1);
    issue("MULHU_busy",   OP_MULHU,1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MD_LAT, 1);
`else
    issue("MUL_3_4",      OP_MUL,  1'b0, 32'd3,        32'd4,        32'd0,        MD_LAT, 1);
    issue("MULHU_ff_ff",  OP_MULHU,1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        MD_LAT, 1);
    issue("DIVU_7_0",     OP_DIVU, 1'b0, 32'd7,        32'd0,        32'd0,        MD_LAT, 1);
    issue("REM_eq",       OP_REM,  1'b0, 32'd5,        32'd5,        32'd0,        MD_LAT, 1);
    issue("MULHU_busy",   OP_MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        MD_LAT, 1);
`endif
    repeat (5) begin
      @(negedge clk);
      chk("busy_in_ready", {31'b0, in_ready}, {31'b0, BUSY_READY});
    end
    @(posedge clk); #1;
    wait_drain();

    // Stall the consumer, then retire and reload on the same edge.
    out_ready = 1'b0;
    issue("ADD_hold", OP_ADD, 1'b0, 32'd21, 32'd21, 32'd42, -1, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_res", res, 32'd42);
      chk("hold_eq", {31'b0, eq}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue("ADD_reload", OP_ADD, 1'b0, 32'd1, 32'd2, 32'd3, 0, 1);
    wait_drain();

    // Flush mid-op, with a competing in_valid that must be dropped.
    out_ready = 1'b0;
    issue("DIV_flushed", OP_DIV, 1'b0, 32'd100, 32'd7, 32'd0, -1, 0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; src_a = 32'd1; src_b = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an op.
    out_ready = 1'b0;
    issue("DIV_reset", OP_DIV, 1'b0, 32'd9, 32'd9, 32'd0, -1, 0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_eq", {31'b0, eq}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue("ADD_after_rst", OP_ADD, 1'b0, 32'd6, 32'd6, 32'd12, 0, 1);
    wait_drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core's combinational ALU. It adds registered outputs, a correct signed compare, an explicit arithmetic-shift select and an iterative RV-M multiply/divide unit.
- Sits in EX, between the operand muxes and the EX/MEM register.
- Single-cycle ops complete in 1 cycle. MUL/DIV ops take XLEN+1 cycles.
- The pipeline stalls on in_ready / out_valid.

Parameters:
- XLEN, 32, operand and result width (8..64, even).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op valid
- in_ready  output  1  unit can accept an op this cycle
- op  input  4  0 ADD, 1 SLT, 2 SLTU, 3 XOR, 4 OR, 5 AND, 6 SLL, 7 SR, 8 SUB, 9 MUL, 10 MULH, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU
- arith  input  1  for SR: 1 = arithmetic, 0 = logical; ignored otherwise
- src_a  input  XLEN  operand A
- src_b  input  XLEN  operand B; shift amount = src_b[$clog2(XLEN)-1:0]
- flush  input  1  synchronous kill of in-flight op
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- res  output  XLEN  result
- eq  output  1  registered (src_a == src_b) of the accepted op

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, res=0, eq=0, counter=0, all datapath regs=0.
  - Release is synchronous to clk.
- States:
  - IDLE: no result held.
  - BUSY: iterating MUL/DIV.
  - DONE: result held, out_valid=1.
- Handshake:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept when in_valid && in_ready. Operands are captured only at accept.
  - Result is consumed when out_valid && out_ready.
  - res and eq are stable while out_valid=1 and out_ready=0.
- Single-cycle ops (0..8):
  - Accept at edge k; DONE with res valid after edge k (latency 1).
  - Back-to-back accepts give 1 op/cycle when out_ready=1.
- Single-cycle arithmetic and width rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is a signed compare; SLTU is unsigned. Both produce zero-extended 0/1.
  - SLL/SR shift by src_b low bits only. SR with arith=1 sign-fills.
- MUL/DIV ops (9..15), iteration:
  - On accept, go to BUSY and load counter=XLEN.
  - Compute |a| and |b| where the op is signed.
  - Iterate one bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - When counter reaches 0, apply the sign fix-up and go to DONE.
  - Total: accept to out_valid = XLEN+1 edges. in_ready=0 throughout BUSY.
- MUL/DIV results:
  - MUL returns the low XLEN bits of the product.
  - MULH returns the high bits of signed×signed; MULHU returns the high bits of unsigned×unsigned.
  - DIV/REM use signed operands and truncate toward zero. REM takes the sign of the dividend.
- Divide boundary cases:
  - Divide by zero: quotient = all ones; remainder = src_a. No iteration is skipped; latency is unchanged.
  - Signed overflow (src_a = -2^(XLEN-1), src_b = -1): DIV = src_a, REM = 0.
- Flush:
  - Forces IDLE and out_valid=0 on the next edge, from any state. No result is emitted for the killed op.
  - flush has priority over accept: an in_valid in the same cycle is dropped.
- Simultaneous events:
  - In DONE with out_ready=1 and a new accept: the old result retires and the new op loads in the same edge.
  - Next state is DONE for a single-cycle op, BUSY for MUL/DIV.
- Reset mid-BUSY: abandons the op immediately (async) and returns all outputs to reset values.
- op decode: every op value is defined; there is no illegal encoding.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: ops 9..15 behave as above.
- Undefined:
  - No multiply/divide datapath or counter is instantiated; BUSY is unreachable.
  - Ops 9..15 complete as single-cycle ops with res=0, eq as normal.

Test Plan:
- ADD 5+7, out_ready=1 -> out_valid 1 cycle after accept, res=12. 10 back-to-back ADDs -> 10 results in 10 consecutive cycles.
- SLT a=0xFFFFFFFF, b=1 -> res=1; SLTU same operands -> res=0. SR a=0x80000000, b=4: arith=1 -> 0xF8000000, arith=0 -> 0x08000000.
- MULHU a=b=0xFFFFFFFF -> res=0xFFFFFFFE at exactly 33 edges after accept. MULH same -> 0. MUL same -> 1. in_ready=0 during BUSY.
- DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIV -7/2 -> -3; REM -7/2 -> -1.
- Hold out_ready=0 for 5 cycles after an ADD result -> res/eq stable, in_ready=0. Then drive out_ready=1 with a new in_valid -> old result retires and new op loads on the same edge.
- Start DIV, assert flush at cycle 10 -> IDLE next edge, no out_valid. Start DIV, pulse rst_n=0 mid-BUSY -> out_valid/res=0 immediately. Rebuild without ALU_SEQ_MULDIV_EN: MUL 3×4 -> res=0 after 1 cycle.
